// File: rtl/uart_rx_frame_ctl.sv
// Frame receive controller: SOF, opcode, length, payload (+ optional XOR checksum when
// UART_RX_FRAME_CHKSUM_EN is defined), buffered and presented through a valid/ready handshake.
module uart_rx_frame_ctl #(
    parameter int          MAX_LEN     = 16,
    parameter int          TIMEOUT_CYC = 50_000,
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    localparam int         W           = $clog2(MAX_LEN + 1),
    localparam int         AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk_rx,
    input  logic          rst_clk_rx_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_data_rdy,
    input  logic          frm_err,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_opcode,
    output logic [W-1:0]  cmd_len,
    input  logic [AW-1:0] pay_rd_addr,
    output logic [7:0]    pay_rd_data,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic          drop_pulse
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ERR_FRAME   = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_LEN,
        ST_PAY,
`ifdef UART_RX_FRAME_CHKSUM_EN
        ST_CHK,
`endif
        ST_HOLD
    } state_t;

`ifdef UART_RX_FRAME_CHKSUM_EN
    localparam state_t ST_END = ST_CHK;
    localparam logic [1:0] ERR_CHKSUM = 2'd2;
    logic [7:0] chk_q, chk_d;
`else
    localparam state_t ST_END = ST_HOLD;
`endif

    state_t        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [W-1:0]  len_q, len_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_pulse_q, err_pulse_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          drop_pulse_q, drop_pulse_d;
    logic          in_frame;
    logic          err_now;
    logic [1:0]    err_sel;
    logic          pay_we;

    logic [7:0] pay_mem [MAX_LEN];

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        len_d        = len_q;
        idx_d        = idx_q;
`ifdef UART_RX_FRAME_CHKSUM_EN
        chk_d        = chk_q;
`endif
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        drop_pulse_d = 1'b0;
        err_now      = 1'b0;
        err_sel      = ERR_FRAME;
        pay_we       = 1'b0;

        in_frame = (state_q == ST_OPC) || (state_q == ST_LEN) || (state_q == ST_PAY)
`ifdef UART_RX_FRAME_CHKSUM_EN
                   || (state_q == ST_CHK)
`endif
                   ;
        tmo_d = in_frame ? tmo_q + TW'(1) : '0;
        if (rx_data_rdy) begin
            tmo_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_data_rdy && !frm_err && rx_data == SOF_BYTE) begin
                    state_d = ST_OPC;
                    tmo_d   = '0;
                end
            end
            ST_HOLD: begin
                // Bytes are never parsed while a frame is held, not even SOF.
                if (rx_data_rdy) begin
                    drop_pulse_d = 1'b1;
                end
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (rx_data_rdy && frm_err) begin
                    err_now = 1'b1;
                    err_sel = ERR_FRAME;
                end else if (rx_data_rdy) begin
                    case (state_q)
                        ST_OPC: begin
                            opcode_d = rx_data;
`ifdef UART_RX_FRAME_CHKSUM_EN
                            chk_d    = rx_data;
`endif
                            state_d  = ST_LEN;
                        end
                        ST_LEN: begin
                            if (rx_data > 8'(MAX_LEN)) begin
                                err_now = 1'b1;
                                err_sel = ERR_LEN;
                            end else begin
                                len_d   = W'(rx_data);
                                idx_d   = '0;
`ifdef UART_RX_FRAME_CHKSUM_EN
                                chk_d   = chk_q ^ rx_data;
`endif
                                state_d = (rx_data == 8'd0) ? ST_END : ST_PAY;
                            end
                        end
                        ST_PAY: begin
                            pay_we = 1'b1;
                            idx_d  = idx_q + W'(1);
`ifdef UART_RX_FRAME_CHKSUM_EN
                            chk_d  = chk_q ^ rx_data;
`endif
                            if (idx_q + W'(1) == len_q) begin
                                state_d = ST_END;
                            end
                        end
`ifdef UART_RX_FRAME_CHKSUM_EN
                        ST_CHK: begin
                            if (rx_data == chk_q) begin
                                state_d = ST_HOLD;
                            end else begin
                                err_now = 1'b1;
                                err_sel = ERR_CHKSUM;
                            end
                        end
`endif
                        default: ;
                    endcase
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_now = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end
            end
        endcase

        if (err_now) begin
            err_pulse_d = 1'b1;
            err_code_d  = err_sel;
            state_d     = ST_IDLE;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            state_q      <= ST_IDLE;
            opcode_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= '0;
            drop_pulse_q <= 1'b0;
`ifdef UART_RX_FRAME_CHKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            drop_pulse_q <= drop_pulse_d;
`ifdef UART_RX_FRAME_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // Payload store has no reset: its contents only matter while a frame is held.
    always_ff @(posedge clk_rx) begin
        if (pay_we) begin
            pay_mem[idx_q[AW-1:0]] <= rx_data;
        end
    end

    assign pay_rd_data = pay_mem[pay_rd_addr];
    assign cmd_valid   = (state_q == ST_HOLD);
    assign cmd_opcode  = opcode_q;
    assign cmd_len     = len_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign drop_pulse  = drop_pulse_q;

endmodule

// File: tb/tb_uart_rx_frame_ctl.sv
// Directed bench for uart_rx_frame_ctl: table of frames plus timeout, hold/drop and reset sequences.
module tb_uart_rx_frame_ctl;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;
    localparam int W       = 5;
    localparam int AW      = 4;
`ifdef UART_RX_FRAME_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk_rx = 1'b0;
    logic          rst_clk_rx_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_data_rdy = 1'b0;
    logic          frm_err = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic [7:0]    cmd_opcode;
    logic [W-1:0]  cmd_len;
    logic [AW-1:0] pay_rd_addr = '0;
    logic [7:0]    pay_rd_data;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic          drop_pulse;

    uart_rx_frame_ctl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO), .SOF_BYTE(8'hA5)) dut (
        .clk_rx(clk_rx), .rst_clk_rx_n(rst_clk_rx_n),
        .rx_data(rx_data), .rx_data_rdy(rx_data_rdy), .frm_err(frm_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
        .pay_rd_addr(pay_rd_addr), .pay_rd_data(pay_rd_data),
        .err_pulse(err_pulse), .err_code(err_code), .drop_pulse(drop_pulse)
    );

    always #5 clk_rx = ~clk_rx;

    typedef struct packed {
        logic [7:0]       opc;
        logic [7:0]       len;
        logic [15:0][7:0] pay;
        int               frm_pos;   // stream position after SOF carrying frm_err, -1 none
        bit               bad_chk;
        bit               exp_ok;
        logic [1:0]       exp_code;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int drop_seen = 0;

    always @(negedge clk_rx) begin
        if (err_pulse === 1'b1) err_seen <= err_seen + 1;
        if (drop_pulse === 1'b1) drop_seen <= drop_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_rx);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe);
        rx_data     = d;
        frm_err     = fe;
        rx_data_rdy = 1'b1;
        @(posedge clk_rx);
        #1;
        rx_data_rdy = 1'b0;
        frm_err     = 1'b0;
    endtask

    task automatic handshake(input string name);
        cmd_ready = 1'b1;
        @(posedge clk_rx);
        #1;
        cmd_ready = 1'b0;
        check({name, " valid after ack"}, 32'(cmd_valid), 32'd0);
    endtask

    task automatic check_frame(input string name, input vec_t v);
        check({name, " opcode"}, 32'(cmd_opcode), 32'(v.opc));
        check({name, " len"}, 32'(cmd_len), 32'(v.len));
        for (int i = 0; i < int'(v.len); i++) begin
            pay_rd_addr = AW'(i);
            #0.1;
            check({name, " payload"}, 32'(pay_rd_data), 32'(v.pay[i]));
        end
        @(posedge clk_rx);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] opc, input logic [7:0] len,
                                input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                input int fp, input bit bad, input bit ok, input logic [1:0] code);
        vec_t v;
        v = '0;
        v.opc = opc;
        v.len = len;
        for (int i = 0; i < 16; i++) v.pay[i] = 8'h40 + 8'(i * 7);
        v.pay[0] = p0;
        v.pay[1] = p1;
        v.pay[2] = p2;
        v.frm_pos = fp;
        v.bad_chk = bad;
        v.exp_ok = ok;
        v.exp_code = code;
        return v;
    endfunction

    task automatic run_vector(input int id, input vec_t v, input bit ack);
        logic [7:0] s [24];
        int ns;
        int npay;
        logic [7:0] ck;
        npay  = (int'(v.len) > MAX_LEN) ? 0 : int'(v.len);
        s[0]  = 8'hA5;
        s[1]  = v.opc;
        s[2]  = v.len;
        ns    = 3;
        ck    = v.opc ^ v.len;
        for (int i = 0; i < npay; i++) begin
            s[ns] = v.pay[i];
            ck    = ck ^ v.pay[i];
            ns++;
        end
        if (CHK_ON && int'(v.len) <= MAX_LEN) begin
            s[ns] = v.bad_chk ? ~ck : ck;
            ns++;
        end
        if (v.frm_pos >= 0) ns = v.frm_pos + 2;
        for (int i = 0; i < ns; i++) send_byte(s[i], (v.frm_pos >= 0) && (i == v.frm_pos + 1));
        $display("vec %0d: opc=%02h len=%0d bytes=%0d expect %s code %0d", id, v.opc, v.len, ns,
                 v.exp_ok ? "valid" : "error", v.exp_code);
        if (v.exp_ok) begin
            check($sformatf("vec%0d valid", id), 32'(cmd_valid), 32'd1);
            check($sformatf("vec%0d no err", id), 32'(err_pulse), 32'd0);
            check_frame($sformatf("vec%0d", id), v);
            if (ack) handshake($sformatf("vec%0d", id));
        end else begin
            check($sformatf("vec%0d err_pulse", id), 32'(err_pulse), 32'd1);
            check($sformatf("vec%0d err_code", id), 32'(err_code), 32'(v.exp_code));
            check($sformatf("vec%0d valid low", id), 32'(cmd_valid), 32'd0);
            idle(1);
            check($sformatf("vec%0d pulse one cycle", id), 32'(err_pulse), 32'd0);
            check($sformatf("vec%0d still idle", id), 32'(cmd_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [$];
        vec_t v;
        int e0;
        int d0;

        vt.push_back(mk(8'h10, 8'd3,  8'h11, 8'h22, 8'h33, -1, 0, 1, 2'd0));
        vt.push_back(mk(8'h01, 8'd32, 8'h00, 8'h00, 8'h00, -1, 0, 0, 2'd1));
        vt.push_back(mk(8'h7E, 8'd1,  8'h55, 8'h00, 8'h00, -1, 0, 1, 2'd0));
        vt.push_back(mk(8'h00, 8'd0,  8'h00, 8'h00, 8'h00, -1, 0, 1, 2'd0));
        vt.push_back(mk(8'h3C, 8'd16, 8'hA0, 8'hB1, 8'hC2, -1, 0, 1, 2'd0));
        vt.push_back(mk(8'h10, 8'd17, 8'h00, 8'h00, 8'h00, -1, 0, 0, 2'd1));
        vt.push_back(mk(8'h22, 8'd3,  8'h11, 8'h22, 8'h33,  3, 0, 0, 2'd0));
        vt.push_back(mk(8'h5A, 8'd2,  8'hFF, 8'h00, 8'h00,  0, 0, 0, 2'd0));
`ifdef UART_RX_FRAME_CHKSUM_EN
        vt.push_back(mk(8'h10, 8'd1,  8'h55, 8'h00, 8'h00, -1, 1, 0, 2'd2));
`endif

        // Reset values
        idle(3);
        check("reset cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset err_pulse", 32'(err_pulse), 32'd0);
        check("reset drop_pulse", 32'(drop_pulse), 32'd0);
        check("reset opcode", 32'(cmd_opcode), 32'd0);
        check("reset len", 32'(cmd_len), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        rst_clk_rx_n = 1'b1;
        idle(2);

        // cmd_ready outside HOLD has no effect
        cmd_ready = 1'b1;
        idle(2);
        cmd_ready = 1'b0;
        check("ready in idle", 32'(cmd_valid), 32'd0);

        foreach (vt[i]) run_vector(i, vt[i], 1'b1);

        // Hold: four bytes (including SOF) are dropped, frame stays intact
        run_vector(100, vt[0], 1'b0);
        d0 = drop_seen;
        send_byte(8'hA5, 1'b0);
        check("hold drop_pulse", 32'(drop_pulse), 32'd1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        idle(1);
        $display("hold: sent 4 bytes while held, drops=%0d", drop_seen - d0);
        check("hold drop count", 32'(drop_seen - d0), 32'd4);
        check("hold valid", 32'(cmd_valid), 32'd1);
        check_frame("hold", vt[0]);
        handshake("hold");
        run_vector(101, vt[2], 1'b1);

        // Timeout: silence after opcode
        e0 = err_seen;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        idle(TMO - 1);
        check("tmo early", 32'(err_seen - e0), 32'd0);
        idle(1);
        $display("timeout: silence %0d cycles after opcode", TMO);
        check("tmo err_pulse", 32'(err_pulse), 32'd1);
        check("tmo err_code", 32'(err_code), 32'd3);
        check("tmo valid", 32'(cmd_valid), 32'd0);
        idle(1);

        // Byte arriving exactly at expiry wins
        e0 = err_seen;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        idle(TMO - 1);
        send_byte(8'h00, 1'b0);
        if (CHK_ON) send_byte(8'h10, 1'b0);
        $display("timeout edge: len byte at expiry cycle");
        check("tmo edge no err", 32'(err_seen - e0), 32'd0);
        check("tmo edge valid", 32'(cmd_valid), 32'd1);
        check("tmo edge opcode", 32'(cmd_opcode), 32'h10);
        check("tmo edge code held", 32'(err_code), 32'd3);
        handshake("tmo edge");

        // Reset mid-payload
        e0 = err_seen;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        rst_clk_rx_n = 1'b0;
        #2;
        $display("reset: asserted mid-payload");
        check("midrst valid", 32'(cmd_valid), 32'd0);
        check("midrst opcode", 32'(cmd_opcode), 32'd0);
        check("midrst len", 32'(cmd_len), 32'd0);
        check("midrst err_code", 32'(err_code), 32'd0);
        idle(2);
        rst_clk_rx_n = 1'b1;
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        idle(TMO + 2);
        check("midrst no err", 32'(err_seen - e0), 32'd0);
        check("midrst idle", 32'(cmd_valid), 32'd0);
        run_vector(102, vt[4], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
